// File: rtl/kbd_pkg.sv
// Shared constants, decoder state encoding and key-map helper for the
// PS/2 keyboard front end.
package kbd_pkg;

   // Scan codes (set 2)
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;

   // Bit positions in key_pulse / key_held
   localparam int KEY_UP    = 3;
   localparam int KEY_ESC   = 2;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_ENTER = 0;
   localparam int NUM_KEYS  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_e;

   // One-hot key mask for a code; zero for anything unmapped (including
   // E1 Pause and the keypad 8/2 aliases of Up/Down without the E0 prefix).
   function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code,
                                                   input logic       ext);
      logic [NUM_KEYS-1:0] m;
      m = '0;
      if (ext && code == SC_UP)      m[KEY_UP]    = 1'b1;
      if (ext && code == SC_DOWN)    m[KEY_DOWN]  = 1'b1;
      if (code == SC_ENTER)          m[KEY_ENTER] = 1'b1;
      if (!ext && code == SC_ESC)    m[KEY_ESC]   = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/keyboard_key_decoder_ps2_rx.sv
// PS/2 receiver: synchronizes the raw lines, shifts in 11-bit frames on
// falling clock edges, checks start/parity/stop and abandons stalled frames.
module ps2_rx #(
   parameter int TIMEOUT_CYCLES = 65000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       rx_tout
);
   import kbd_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1_q, clk_s2_q, clk_prev_q;
   logic          dat_s1_q, dat_s2_q;
   logic [10:0]   shift_q, shift_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_err_q, rx_err_d;
   logic          rx_tout_q, rx_tout_d;

   logic          fall;
   logic [10:0]   frame;
   logic          frame_ok;

   assign fall     = clk_prev_q & ~clk_s2_q;
   // Shift register contents after the bit being sampled this cycle
   assign frame    = {dat_s2_q, shift_q[10:1]};
   // start=0, stop=1, odd parity over d0..d7 plus parity bit
   assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

   // Two-flop synchronizers; lines reset to the idle-high level so reset
   // release never looks like a falling edge
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
      end
   end

   // Bit collection, frame check on the stop bit, and stall timeout
   always_comb begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      to_cnt_d   = to_cnt_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      rx_tout_d  = 1'b0;
      if (fall) begin
         shift_d  = frame;
         to_cnt_d = '0;
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if (frame_ok) begin
               rx_byte_d  = frame[8:1];
               rx_valid_d = 1'b1;
            end else begin
               rx_err_d = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            bit_cnt_d = 4'd0;
            to_cnt_d  = '0;
            rx_tout_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // Receiver state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         to_cnt_q   <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_tout_q  <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         to_cnt_q   <= to_cnt_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         rx_tout_q  <= rx_tout_d;
      end
   end

   assign rx_byte  = rx_byte_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;
   assign rx_tout  = rx_tout_q;

endmodule

// File: rtl/keyboard_key_decoder.sv
// Keyboard front end: PS/2 receiver plus E0/F0 prefix FSM producing
// one-cycle press strobes and held-key levels for Up/Escape/Down/Enter.
module keyboard_key_decoder #(
   parameter int TIMEOUT_CYCLES = 65000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] key_pulse,
   output logic [3:0] key_held,
   output logic       frame_err
);
   import kbd_pkg::*;

   logic [7:0]          rx_byte;
   logic                rx_valid, rx_err, rx_tout;

   dec_state_e          state_q, state_d;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] pulse_q, pulse_d;
   logic [NUM_KEYS-1:0] mask;

   ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .rx_tout  (rx_tout)
   );

   assign mask = key_mask(rx_byte, (state_q == ST_EXT) || (state_q == ST_EXT_BRK));

   // Prefix FSM; make only pulses on the first press, so typematic repeats
   // are silent. Masks are one-hot, so at most one pulse bit per cycle.
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      pulse_d = '0;
      if (rx_err || rx_tout) begin
         state_d = ST_IDLE;
      end else if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (rx_byte == SC_BRK) begin
                  state_d = ST_BRK;
               end else begin
                  pulse_d = mask & ~held_q;
                  held_d  = held_q | mask;
               end
            end
            ST_EXT: begin
               if (rx_byte == SC_BRK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  pulse_d = mask & ~held_q;
                  held_d  = held_q | mask;
                  state_d = ST_IDLE;
               end
            end
            ST_BRK, ST_EXT_BRK: begin
               held_d  = held_q & ~mask;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Decoder state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         held_q  <= '0;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         pulse_q <= pulse_d;
      end
   end

   assign key_pulse = pulse_q;
   assign key_held  = held_q;
   assign frame_err = rx_err;

endmodule

// File: tb/tb_keyboard_key_decoder.sv
// Directed bench for keyboard_key_decoder: PS/2 frames are driven on the pins,
// expected strobes (value and cycle) go into a scoreboard queue, and a
// negedge monitor pops and checks every strobe the design produces.
module tb_keyboard_key_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] key_pulse;
   logic [3:0] key_held;
   logic       frame_err;

   localparam int H = 10;  // half PS/2 bit period in clk cycles

   typedef struct {
      bit         is_err;
      logic [3:0] val;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   keyboard_key_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_pulse (key_pulse),
      .key_held  (key_held),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      if (key_pulse != 4'b0000 || frame_err == 1'b1) begin
         tests++;
         assert (sbq.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_strobe pulse=%b err=%b cyc=%0d", key_pulse, frame_err, cyc);
         end
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            tests++;
            assert (frame_err === e.is_err && key_pulse === (e.is_err ? 4'b0000 : e.val) && cyc === e.cyc) else begin
               fails++;
               $error("FAIL strobe got pulse=%b err=%b cyc=%0d expected pulse=%b err=%b cyc=%0d",
                      key_pulse, frame_err, cyc, e.val, e.is_err, e.cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] ep, input logic [3:0] eh, input logic ee);
      tests++;
      assert (key_pulse === ep && key_held === eh && frame_err === ee) else begin
         fails++;
         $error("FAIL %s got pulse=%b held=%b err=%b expected pulse=%b held=%b err=%b",
                tag, key_pulse, key_held, frame_err, ep, eh, ee);
      end
   endtask

   // Full frame; expectation pushed at the stop-bit falling edge, held level
   // checked in the cycle the press strobe is due
   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input logic [3:0] exp_pulse, input logic [3:0] exp_held);
      logic [10:0] f;
      logic        p;
      int          sc;
      exp_t        e;
      p = bad_par ? (^b) : ~(^b);
      f = {1'b1, p, b, 1'b0};
      for (int i = 0; i < 10; i++) ps2_bit(f[i]);
      ps2_data = 1'b1;
      tick(H);
      ps2_clk = 1'b0;
      sc = cyc;
      if (bad_par) begin
         e.is_err = 1'b1; e.val = 4'b0000; e.cyc = sc + 3;
         sbq.push_back(e);
      end else if (exp_pulse != 4'b0000) begin
         e.is_err = 1'b0; e.val = exp_pulse; e.cyc = sc + 4;
         sbq.push_back(e);
      end
      tick(4);
      tests++;
      assert (key_held === exp_held) else begin
         fails++;
         $error("FAIL held_after_%h got %b expected %b", b, key_held, exp_held);
      end
      tick(H - 4);
      ps2_clk = 1'b1;
      tick(3 * H);
   endtask

   task automatic send_partial(input logic [7:0] b, input int n);
      logic [10:0] f;
      f = {1'b1, ~(^b), b, 1'b0};
      for (int i = 0; i < n; i++) ps2_bit(f[i]);
      ps2_data = 1'b1;
   endtask

   initial begin
      // reset
      rst = 1'b1;
      tick(3);
      check_outs("reset", 4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;
      tick(5);

      // E0 75: Up press
      send_frame(8'hE0, 0, 4'b0000, 4'b0000);
      send_frame(8'h75, 0, 4'b1000, 4'b1000);

      // typematic repeats, then E0 F0 75 release
      send_frame(8'hE0, 0, 4'b0000, 4'b1000);
      send_frame(8'h75, 0, 4'b0000, 4'b1000);
      send_frame(8'hE0, 0, 4'b0000, 4'b1000);
      send_frame(8'h75, 0, 4'b0000, 4'b1000);
      send_frame(8'hE0, 0, 4'b0000, 4'b1000);
      send_frame(8'hF0, 0, 4'b0000, 4'b1000);
      send_frame(8'h75, 0, 4'b0000, 4'b0000);

      // Enter, release, keypad Enter, release
      send_frame(8'h5A, 0, 4'b0001, 4'b0001);
      send_frame(8'hF0, 0, 4'b0000, 4'b0001);
      send_frame(8'h5A, 0, 4'b0000, 4'b0000);
      send_frame(8'hE0, 0, 4'b0000, 4'b0000);
      send_frame(8'h5A, 0, 4'b0001, 4'b0001);
      send_frame(8'hE0, 0, 4'b0000, 4'b0001);
      send_frame(8'hF0, 0, 4'b0000, 4'b0001);
      send_frame(8'h5A, 0, 4'b0000, 4'b0000);

      // bad parity, then Escape press/release
      send_frame(8'h5A, 1, 4'b0000, 4'b0000);
      send_frame(8'h76, 0, 4'b0100, 4'b0100);
      send_frame(8'hF0, 0, 4'b0000, 4'b0100);
      send_frame(8'h76, 0, 4'b0000, 4'b0000);

      // keypad 2 without prefix is not Down
      send_frame(8'h72, 0, 4'b0000, 4'b0000);

      // stalled partial frame abandoned silently, then E0 72
      send_partial(8'h72, 5);
      tick(65100);
      send_frame(8'hE0, 0, 4'b0000, 4'b0000);
      send_frame(8'h72, 0, 4'b0010, 4'b0010);
      send_frame(8'hE0, 0, 4'b0000, 4'b0010);
      send_frame(8'hF0, 0, 4'b0000, 4'b0010);
      send_frame(8'h72, 0, 4'b0000, 4'b0000);

      // reset mid-frame after a prefix, with Escape held
      send_frame(8'h76, 0, 4'b0100, 4'b0100);
      send_frame(8'hE0, 0, 4'b0000, 4'b0100);
      send_partial(8'h75, 6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_outs("mid_frame_reset", 4'b0000, 4'b0000, 1'b0);
      tick(2 * H);
      send_frame(8'h75, 0, 4'b0000, 4'b0000);

      tick(20);
      tests++;
      assert (sbq.size() == 0) else begin
         fails++;
         $error("FAIL missing_strobes got %0d pending expected 0", sbq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keyboard_key_decoder.md
# keyboard_key_decoder

Front-end stage for the menu and game FSMs: receives raw PS/2 traffic from the keyboard, deserializes and checks each frame, and tracks make/break sequences. It emits a 4-bit one-cycle key-press vector, `key_pulse`, which drives the menu controller's `keyboard_in` directly. It also emits held-key levels for gameplay logic and an error strobe.

## Interface
- `TIMEOUT_CYCLES`, default 65000: clk cycles without a PS/2 falling edge before a partial frame is abandoned (about 1 ms at 65 MHz).
- `clk`, in, 1: system clock, 65 MHz.
- `rst`, in, 1: reset, synchronous, active-high.
- `ps2_clk`, in, 1: raw PS/2 clock, asynchronous.
- `ps2_data`, in, 1: raw PS/2 data, asynchronous.
- `key_pulse`, out, 4: one-cycle press strobes. [3]=Up, [2]=Escape, [1]=Down, [0]=Enter.
- `key_held`, out, 4: level per key, same bit mapping; high between make and break.
- `frame_err`, out, 1: one-cycle strobe on a rejected frame.

## Operation
- Reset clears all outputs, `key_held`, prefix state, receiver bit counter and timeout counter.
- Receiver:
  - 2-FF synchronizers on both PS/2 lines.
  - A falling edge is detected when the synchronized clock is 1 in the previous sample and 0 in the current one.
  - On each falling edge, sample synchronized data into an 11-bit shift register, LSB first: start, d0..d7, parity, stop.
- Frame check: start=0, odd parity over d0..d7+parity, stop=1.
  - Pass: the byte is delivered.
  - Fail: pulse `frame_err`, deliver nothing, and force the decoder to IDLE.
- Timeout:
  - The counter resets on every falling edge and counts only while 1–10 bits are collected.
  - At `TIMEOUT_CYCLES` the bit count clears and the decoder returns to IDLE.
  - No `frame_err` is raised.
- Decoder FSM on each delivered byte:
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - Any other byte: make(code, ext=0), stay IDLE.
  - EXT:
    - F0 → EXT_BRK.
    - Any other byte: make(code, ext=1) → IDLE.
  - BRK: break(code, ext=0) → IDLE.
  - EXT_BRK: break(code, ext=1) → IDLE.
  - E1 (Pause) and unmapped codes are ignored; the FSM returns to IDLE.
- Key map:
  - Up = E0 75.
  - Down = E0 72.
  - Enter = 5A or E0 5A (keypad Enter).
  - Escape = 76.
  - Non-extended 75/72 (keypad 8/2) are ignored.
- make(k):
  - If `key_held[k]`=0: set it and pulse `key_pulse[k]`.
  - If already held (typematic repeat): no pulse.
- break(k): clear `key_held[k]`; no pulse.
- At most one `key_pulse` bit is high in any cycle.

## Timing
- Let E be the clk cycle in which the stop-bit falling edge is detected. Then:
  - E+1: byte valid internally, or `frame_err` high for one cycle.
  - E+2: `key_pulse` bit high for exactly one cycle; `key_held` updates in the same cycle.
- Input synchronizers add 2 cycles between a `ps2_clk` pin edge and its detection.
- Back-to-back bytes are separated by at least 1 PS/2 bit time (≥ 3000 clk), so no input buffering is required.
- `rst` asserted mid-frame:
  - Partial frame discarded.
  - `key_held` cleared.
  - Outputs 0 from the cycle after the `rst` sample.
  - Reception resumes at the next start bit after `rst` deasserts.

## Structure
- Package `kbd_pkg`:
  - Scan-code constants: `SC_EXT`=E0, `SC_BRK`=F0, `SC_UP`=75, `SC_DOWN`=72, `SC_ENTER`=5A, `SC_ESC`=76.
  - Key index constants: `KEY_UP`=3, `KEY_ESC`=2, `KEY_DOWN`=1, `KEY_ENTER`=0.
  - Decoder state encoding.
- Sub-module `ps2_rx`: synchronizers, edge detect, shift register, frame check, timeout. Outputs `rx_byte[7:0]`, `rx_valid`, `rx_err`.
- The top level holds the prefix FSM and `key_held` register.

## Test plan
- Frame sequence E0 75 → one `key_pulse`=4'b1000 at E+2 of the second frame; `key_held[3]`=1.
- Frame sequence E0 75, E0 75, E0 75 (typematic), then E0 F0 75 → single pulse; `key_held[3]` clears 2 cycles after the last stop edge.
- 5A, then F0 5A, then E0 5A → `key_pulse`=4'b0001 twice total, with `key_held[0]` low between them.
- Byte 5A sent with even parity → `frame_err` pulse at E+1; no `key_pulse`; a following valid 76 yields `key_pulse`=4'b0100.
- 5 bits of a frame, then idle > 65000 cycles, then a full 72 frame preceded by E0 → Down pulse only; `frame_err` never asserted.
- `rst` held 1 cycle after E0 and 6 bits of 75 → all outputs 0; a subsequent non-extended 75 produces no pulse.
